// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory answering execute-stage
// loads and stores. Optional wait states stall the pipeline; the response
// (rvalid/rdata/err) is registered and appears the cycle after the access.
//
// Handshake: a request (mem_read_i | mem_write_i) is held stable by the
// requester while mem_stall_o is high. The access is performed at the first
// rising edge where the request is present and mem_stall_o is low. Dropping
// the request during a stall abandons it with no response. mem_rvalid_o is a
// single-cycle pulse with no back-pressure.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [3:0]  mem_strb_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic        mem_stall_o,
    output logic        mem_rvalid_o,
    output logic [31:0] mem_rdata_o,
    output logic        mem_err_o
);

    localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_L  = 30'(DEPTH_WORDS);
    localparam bit          HAS_WAIT = (WAIT_STATES > 0);
    // First value of the wait counter; the IDLE cycle itself is one stall.
    localparam logic [3:0]  WS_INIT  = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH_WORDS];

    logic          req;
    logic          both;
    logic [29:0]   word_off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          do_access;
    logic          access_ok;
    logic          do_store;
    logic          stall_raw;
    logic          unused_addr_lsb;

    assign req             = mem_read_i | mem_write_i;
    assign both            = mem_read_i & mem_write_i;
    // BASE_ADDR is word aligned, so the subtraction can ignore the byte bits.
    assign word_off        = mem_addr_i[31:2] - BASE_ADDR[31:2];
    assign in_range        = (mem_addr_i >= BASE_ADDR) && (word_off < DEPTH_L);
    assign idx             = word_off[AW-1:0];
    assign unused_addr_lsb = ^mem_addr_i[1:0];

    // Decide whether this cycle stalls or performs the access; both are
    // suppressed while reset is asserted.
    always_comb begin
        stall_raw = 1'b0;
        do_access = 1'b0;
        if (rst_ni && req) begin
            case (state)
                S_IDLE: begin
                    if (HAS_WAIT) stall_raw = 1'b1;
                    else          do_access = 1'b1;
                end
                S_WAIT: begin
                    if (cnt != 4'd0) stall_raw = 1'b1;
                    else             do_access = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_stall_o = stall_raw;
    assign access_ok   = do_access & in_range & ~both;
    assign do_store    = access_ok & mem_write_i;

    // Byte-strobed array write; the array has no reset.
    always_ff @(posedge clk_i) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_strb_i[b]) mem[idx][8*b +: 8] <= mem_data_i[8*b +: 8];
            end
        end
    end

    // Wait-state FSM plus the registered response it produces.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            mem_rvalid_o <= 1'b0;
            mem_err_o    <= 1'b0;
            mem_rdata_o  <= 32'd0;
        end else begin
            if (do_access) begin
                mem_rvalid_o <= 1'b1;
                mem_err_o    <= ~access_ok;
                mem_rdata_o  <= (access_ok && mem_read_i) ? mem[idx] : 32'd0;
            end else begin
                mem_rvalid_o <= 1'b0;
                mem_err_o    <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (req && HAS_WAIT) begin
                        state <= S_WAIT;
                        cnt   <= WS_INIT;
                    end
                end
                S_WAIT: begin
                    // Completion or a flushed request both return to IDLE.
                    if (!req || cnt == 4'd0) begin
                        state <= S_IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule
